// File: rtl/l1d_port_arbiter.sv
// l1d_port_arbiter: shares one L1D request/response port between the
// load/store unit (requester 0) and the prefetch/page-walk engine
// (requester 1). Round-robin grant into a one-entry issue slot, a per-requester
// outstanding-request limit, and response routing by the requester-ID tag MSB.
module l1d_port_arbiter #(
    parameter int unsigned TAG_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    // requester side
    input  logic [1:0]                req_valid_in,
    output logic [1:0]                req_ready_out,
    input  logic [1:0]                req_we_in,
    input  logic [1:0][63:0]          req_addr_in,
    input  logic [1:0][63:0]          req_value_in,
    input  logic [1:0][TAG_WIDTH-1:0] req_tag_in,
    // L1D request side
    output logic                      l1d_valid_out,
    input  logic                      l1d_ready_in,
    output logic                      l1d_we_out,
    output logic [63:0]               l1d_addr_out,
    output logic [63:0]               l1d_value_out,
    output logic [TAG_WIDTH:0]        l1d_tag_out,
    // L1D response side
    input  logic                      l1d_resp_valid_in,
    input  logic [TAG_WIDTH:0]        l1d_resp_tag_in,
    input  logic [63:0]               l1d_resp_value_in,
    input  logic                      l1d_resp_we_in,
    // routed responses
    output logic [1:0]                resp_valid_out,
    output logic [TAG_WIDTH-1:0]      resp_tag_out,
    output logic [63:0]               resp_value_out,
    output logic                      resp_we_out,
    output logic                      err_out
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DATA_W = 64;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    // issue slot and arbitration state
    slot_state_e           state_q;
    logic                  ptr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     addr_q;
    logic [DATA_W-1:0]     value_q;
    logic [TAG_WIDTH:0]    tag_q;

    // outstanding counters
    logic [CNT_W-1:0]      cnt_q [2];
    logic [CNT_W-1:0]      cnt_d [2];

    // response path
    logic [1:0]            resp_valid_q;
    logic [TAG_WIDTH-1:0]  resp_tag_q;
    logic [DATA_W-1:0]     resp_value_q;
    logic                  resp_we_q;
    logic                  err_q;
    logic                  err_d;

    // arbitration signals
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic                  grant_id;
    logic                  both_elig;
    logic                  slot_free;
    logic                  hs;
    logic [1:0]            inc;
    logic [1:0]            resp_hit;
    logic [1:0]            dec;
    logic                  bad_resp;

    // Eligibility, round-robin choice and the combinational accept
    always_comb begin
        eligible  = 2'b00;
        grant     = 2'b00;
        grant_id  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_valid_in[i] & (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
        both_elig = &eligible;
        if (both_elig) begin
            grant_id = ptr_q;
        end else if (eligible[1]) begin
            grant_id = 1'b1;
        end
        if (|eligible) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
        // a stalled slot blocks new grants, so no re-arbitration while stalled
        slot_free     = (state_q == S_EMPTY) | l1d_ready_in;
        req_ready_out = grant & {2{slot_free}};
        hs            = |(req_valid_in & req_ready_out);
    end

    // Counter next-state: +1 on handshake, -1 on a response, both -> hold
    always_comb begin
        inc      = hs ? grant : 2'b00;
        resp_hit = 2'b00;
        if (l1d_resp_valid_in) begin
            resp_hit = l1d_resp_tag_in[TAG_WIDTH] ? 2'b10 : 2'b01;
        end
        dec      = 2'b00;
        bad_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            dec[i]   = resp_hit[i] & (cnt_q[i] != '0);
            // a response with nothing outstanding is a protocol error; count stays put
            if (resp_hit[i] && (cnt_q[i] == '0)) begin
                bad_resp = 1'b1;
            end
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        err_d = err_q | bad_resp;
    end

    // Issue slot FSM with latched request fields and round-robin pointer
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_EMPTY;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (hs) begin
                        state_q <= S_FULL;
                    end
                end
                S_FULL: begin
                    // a same-cycle handshake refills the slot back-to-back
                    if (!hs && l1d_ready_in) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
            if (hs) begin
                we_q    <= req_we_in[grant_id];
                addr_q  <= req_addr_in[grant_id];
                value_q <= req_value_in[grant_id];
                tag_q   <= {grant_id, req_tag_in[grant_id]};
                // pointer only moves when there was an actual contest
                if (both_elig) begin
                    ptr_q <= ~grant_id;
                end
            end
        end
    end

    // Outstanding counters and sticky error flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    // Registered one-cycle response routing
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            resp_valid_q <= 2'b00;
            resp_tag_q   <= '0;
            resp_value_q <= '0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= resp_hit;
            if (l1d_resp_valid_in) begin
                resp_tag_q   <= l1d_resp_tag_in[TAG_WIDTH-1:0];
                resp_value_q <= l1d_resp_value_in;
                resp_we_q    <= l1d_resp_we_in;
            end
        end
    end

    assign l1d_valid_out  = (state_q == S_FULL);
    assign l1d_we_out     = we_q;
    assign l1d_addr_out   = addr_q;
    assign l1d_value_out  = value_q;
    assign l1d_tag_out    = tag_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_tag_out   = resp_tag_q;
    assign resp_value_out = resp_value_q;
    assign resp_we_out    = resp_we_q;
    assign err_out        = err_q;

endmodule
